// File: rtl/mem_bridge_if.sv
// Bus side of the core-to-memory bridge.
// One request phase (req/addr_ok) and one data phase (data_ok/rdata).
interface mem_bridge_if;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_wr_o,
        output bus_addr_o,
        output bus_wdata_o,
        input  bus_addr_ok_i,
        input  bus_data_ok_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_wr_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        output bus_addr_ok_i,
        output bus_data_ok_i,
        output bus_rdata_i
    );
endinterface

// File: rtl/mem_bridge.sv
// Memory-stage bridge: turns one core load/store into a bus transfer,
// stalling the core until done and aborting with a sticky error on timeout.
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_en_i,
    input  logic         memwrite_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         stall_o,
    output logic         err_o,
    mem_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    stateT       state;
    stateT       stateNext;
    stateT       outState;
    logic        isWrite;
    logic [31:0] addrLat;
    logic [31:0] wdataLat;
    logic [15:0] toCnt;
    logic        accept;
    logic        inFlight;
    logic        complete;
    logic        timedOut;

    always_comb begin
        accept   = (state == IDLE) && mem_en_i;
        inFlight = (state == REQ) || (state == WAIT);
        complete = ((state == REQ) && bus.bus_addr_ok_i
                    && bus.bus_data_ok_i)
                || ((state == WAIT) && bus.bus_data_ok_i);
        // Completion on the last allowed cycle beats the timeout.
        timedOut = inFlight && (toCnt == TO_LAST) && !complete;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (mem_en_i) stateNext = REQ;
            end
            REQ: begin
                if (complete || timedOut) begin
                    stateNext = DONE;
                end else if (bus.bus_addr_ok_i) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (complete || timedOut) stateNext = DONE;
            end
            DONE: begin
                // The core still shows the finished access here.
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        outState        = rst ? IDLE : state;
        stall_o         = 1'b0;
        bus.bus_req_o   = 1'b0;
        bus.bus_wr_o    = 1'b0;
        bus.bus_addr_o  = '0;
        bus.bus_wdata_o = '0;
        unique case (1'b1)
            outState == IDLE: begin
                stall_o = mem_en_i;
            end
            outState == REQ: begin
                stall_o         = 1'b1;
                bus.bus_req_o   = 1'b1;
                bus.bus_wr_o    = isWrite;
                bus.bus_addr_o  = addrLat;
                bus.bus_wdata_o = wdataLat;
            end
            outState == WAIT: begin
                stall_o         = 1'b1;
                bus.bus_wr_o    = isWrite;
                bus.bus_addr_o  = addrLat;
                bus.bus_wdata_o = wdataLat;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isWrite  <= 1'b0;
            addrLat  <= '0;
            wdataLat <= '0;
            toCnt    <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            if (accept) begin
                isWrite  <= memwrite_i;
                addrLat  <= addr_i;
                wdataLat <= wdata_i;
                toCnt    <= '0;
            end else if (inFlight) begin
                toCnt <= toCnt + 16'd1;
            end
            if (complete && !isWrite) begin
                rdata_o <= bus.bus_rdata_i;
            end
            if (timedOut) begin
                rdata_o <= '0;
                err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: vector table, reset corner case,
// then random transfers against a transaction-level model.
module tb_mem_bridge;

    localparam int T = 4;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ad;
        int          gd;
        logic [31:0] rd;
        int          gap;
        int          expStall;
        logic [31:0] expRdata;
        logic        expErr;
    } vecT;

    logic        clk = 1'b0;
    logic        rst;
    logic        memEn;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int passCnt = 0;
    int checkCnt = 0;

    logic [31:0] mRdata;
    logic        mErr;

    vecT tbl [8];

    mem_bridge_if bus ();

    mem_bridge #(.TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en_i   (memEn),
        .memwrite_i (memWrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .err_o      (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idleCycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            memEn = 1'b0;
            bus.bus_addr_ok_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.bus_data_ok_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.bus_rdata_i = $urandom;
            @(negedge clk);
            check("gapStall", 32'(stall), 32'd0);
            check("gapReq", 32'(bus.bus_req_o), 32'd0);
            check("gapRdata", rdata, mRdata);
        end
    endtask

    task automatic doTxn(input vecT v, output int stallCnt);
        int  reqCnt;
        int  total;
        int  expStall;
        int  expReq;
        bit  holdOk;
        bit  idleOk;
        bit  doneOk;
        bit  finished;
        stallCnt = 0;
        reqCnt = 0;
        holdOk = 1'b1;
        doneOk = 1'b0;
        finished = 1'b0;
        @(posedge clk); #1;
        memEn = 1'b1;
        memWrite = v.w;
        addr = v.addr;
        wdata = v.wdata;
        bus.bus_addr_ok_i = 1'b0;
        bus.bus_data_ok_i = 1'b0;
        @(negedge clk);
        idleOk = (stall === 1'b1) && (bus.bus_req_o === 1'b0);
        if (stall === 1'b1) stallCnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            bus.bus_addr_ok_i = (k == v.ad + 1);
            bus.bus_data_ok_i = (k == v.ad + 1 + v.gd);
            bus.bus_rdata_i = (k == v.ad + 1 + v.gd) ? v.rd
                            : (32'hDEAD_0000 | 32'(k));
            @(negedge clk);
            if (stall !== 1'b1) begin
                doneOk = (bus.bus_req_o === 1'b0) && (bus.bus_wr_o === 1'b0)
                      && (bus.bus_addr_o === 32'd0)
                      && (bus.bus_wdata_o === 32'd0);
                finished = 1'b1;
                break;
            end
            stallCnt++;
            if (bus.bus_req_o === 1'b1) reqCnt++;
            if (bus.bus_addr_o !== v.addr || bus.bus_wdata_o !== v.wdata
                || bus.bus_wr_o !== v.w) holdOk = 1'b0;
        end
        // Reference: bus finishes on cycle ad+gd+1 of the transfer,
        // unless that exceeds the timeout budget.
        total = v.ad + v.gd + 1;
        expStall = 1 + ((total <= T) ? total : T);
        expReq = (v.ad + 1 < T) ? v.ad + 1 : T;
        if (total <= T) begin
            if (!v.w) mRdata = v.rd;
        end else begin
            mRdata = '0;
            mErr = 1'b1;
        end
        check("txnBound", 32'(finished), 32'd1);
        check("startIdle", 32'(idleOk), 32'd1);
        check("stallCycles", 32'(stallCnt), 32'(expStall));
        check("reqCycles", 32'(reqCnt), 32'(expReq));
        check("busHold", 32'(holdOk), 32'd1);
        check("doneBusZero", 32'(doneOk), 32'd1);
        check("rdata", rdata, mRdata);
        check("err", 32'(err), 32'(mErr));
    endtask

    initial begin
        int sc;
        vecT v;
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h1234_5678,
                   1, 2, 32'h1234_5678, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 3, 32'h7777_7777,
                   1, 5, 32'h1234_5678, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0204, 32'h0, 1, 2, 32'hA5A5_0001,
                   2, 5, 32'hA5A5_0001, 1'b0};
        tbl[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 2, 0, 32'h0BAD_BEEF,
                   1, 4, 32'h0BAD_BEEF, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0003, 32'h0102_0304, 3, 0, 32'h9999_0000,
                   1, 5, 32'h0BAD_BEEF, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0008, 32'h0, 0, 1, 32'h55AA_55AA,
                   0, 3, 32'h55AA_55AA, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0ABC, 32'h0, 15, 0, 32'hFFFF_0000,
                   1, 5, 32'h0000_0000, 1'b1};
        tbl[7] = '{1'b0, 32'h0000_0C00, 32'h0, 0, 0, 32'h1111_2222,
                   0, 2, 32'h1111_2222, 1'b1};

        rst = 1'b1;
        memEn = 1'b0;
        memWrite = 1'b0;
        addr = '0;
        wdata = '0;
        bus.bus_addr_ok_i = 1'b0;
        bus.bus_data_ok_i = 1'b0;
        bus.bus_rdata_i = '0;
        mRdata = '0;
        mErr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstRdata", rdata, 32'd0);
        check("rstErr", 32'(err), 32'd0);
        check("rstStall", 32'(stall), 32'd0);
        check("rstReq", 32'(bus.bus_req_o), 32'd0);
        check("rstAddr", bus.bus_addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycles(1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            idleCycles(tbl[i].gap, 1'b1);
            doTxn(tbl[i], sc);
            check("tblStall", 32'(sc), 32'(tbl[i].expStall));
            check("tblRdata", rdata, tbl[i].expRdata);
            check("tblErr", 32'(err), 32'(tbl[i].expErr));
        end

        // Reset while waiting for data, then a stale data_ok arrives.
        @(posedge clk); #1;
        memEn = 1'b1;
        memWrite = 1'b0;
        addr = 32'h0000_0040;
        bus.bus_addr_ok_i = 1'b0;
        bus.bus_data_ok_i = 1'b0;
        @(posedge clk); #1;
        bus.bus_addr_ok_i = 1'b1;
        @(posedge clk); #1;
        bus.bus_addr_ok_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstMidStall", 32'(stall), 32'd1);
        check("rstMidReq", 32'(bus.bus_req_o), 32'd0);
        check("rstMidAddr", bus.bus_addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        memEn = 1'b0;
        bus.bus_data_ok_i = 1'b1;
        bus.bus_rdata_i = 32'hBADB_AD00;
        @(negedge clk);
        mRdata = '0;
        mErr = 1'b0;
        check("postRstStall", 32'(stall), 32'd0);
        check("postRstRdata", rdata, 32'd0);
        check("postRstErr", 32'(err), 32'd0);
        check("postRstReq", 32'(bus.bus_req_o), 32'd0);
        @(posedge clk); #1;
        bus.bus_data_ok_i = 1'b0;
        @(negedge clk);
        check("staleDataIgnored", rdata, 32'd0);
        check("staleStall", 32'(stall), 32'd0);

        for (int i = 0; i < 150; i++) begin
            v.w = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.wdata = $urandom;
            v.ad = $urandom_range(0, 4);
            v.gd = $urandom_range(0, 3);
            v.rd = $urandom;
            v.gap = $urandom_range(0, 2);
            v.expStall = 0;
            v.expRdata = '0;
            v.expErr = 1'b0;
            idleCycles(v.gap, 1'b1);
            doTxn(v, sc);
        end

        idleCycles(2, 1'b1);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
